// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer between the display prefetch (show-ahead FIFO)
// and a pixel writer. All memory-side outputs are registered; grants are decided one cycle ahead.
module vga_fb_arbiter #(
    parameter int HDISP      = 640,
    parameter int VDISP      = 480,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WM     = 4,
    localparam int NPIX      = HDISP * VDISP,
    localparam int ADDR_W    = $clog2(NPIX)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              VGA_BLANK,
    input  logic              VGA_VS,
    output logic [DATA_W-1:0] pix_data,
    output logic              underflow,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RA_W  = ADDR_W + 1;

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]        state;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rptr, wptr;
    logic [CNT_W-1:0]  count;
    logic [RA_W-1:0]   rd_addr;
    logic              rd_vld;
    logic [CNT_W:0]    level_tot;
    logic              empty, push, pop, low;
    logic              rd_elig, wr_elig, grant_rd, grant_wr;

    // Entries already stored plus reads on the port and on the return bus;
    // bounding this total is what keeps the FIFO from overflowing.
    assign level_tot = {1'b0, count} + {{CNT_W{1'b0}}, mem_re} + {{CNT_W{1'b0}}, rd_vld};
    assign empty     = (count == '0);
    assign low       = (count <= CNT_W'(LOW_WM));
    assign rd_elig   = (state == ST_RUN) && VGA_VS && (rd_addr < RA_W'(NPIX))
                       && (level_tot < (CNT_W+1)'(FIFO_DEPTH));
    // The request acked this cycle is still held by the writer; do not grant it twice.
    assign wr_elig   = wr_req && !wr_ack;
    assign grant_rd  = rd_elig && (low || !wr_elig);
    assign grant_wr  = wr_elig && !grant_rd;
    assign push      = rd_vld && (state == ST_RUN) && VGA_VS;
    assign pop       = VGA_BLANK && !empty;
    assign pix_data  = empty ? '0 : fifo_mem[rptr];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_SYNC;
            rptr      <= '0;
            wptr      <= '0;
            count     <= '0;
            rd_addr   <= '0;
            rd_vld    <= 1'b0;
            underflow <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            wr_ack    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_re <= grant_rd;
            mem_we <= grant_wr;
            wr_ack <= grant_wr;
            rd_vld <= mem_re;
            if (grant_wr) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end else if (grant_rd) begin
                mem_addr <= rd_addr[ADDR_W-1:0];
            end

            if (!VGA_VS) begin
                state     <= ST_FLUSH;
                rptr      <= '0;
                wptr      <= '0;
                count     <= '0;
                rd_addr   <= '0;
                underflow <= 1'b0;
            end else begin
                if (state == ST_FLUSH)
                    state <= ST_RUN;
                else if (state != ST_RUN && state != ST_SYNC)
                    state <= ST_SYNC;
                if (grant_rd) rd_addr <= rd_addr + RA_W'(1);
                if (push)     wptr    <= wptr + PTR_W'(1);
                if (pop)      rptr    <= rptr + PTR_W'(1);
                if (push && !pop)
                    count <= count + CNT_W'(1);
                else if (pop && !push)
                    count <= count - CNT_W'(1);
                if (VGA_BLANK && empty) underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wptr] <= mem_rdata;
    end

endmodule
